// File: rtl/corelet_pkg.sv
// Shared corelet sizing: default psum width, column count and lane depth.
// Pointer width carries one extra bit so full and empty stay distinguishable.
package corelet_pkg;
    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 16;
    localparam int PTR_W   = $clog2(DEPTH) + 1;
endpackage

// File: rtl/psum_col_fifo.sv
// One column lane: storage, wrap-bit pointers, full/empty flags, write accept.
// Latency: a write or pop is visible in the flags after the same edge.
// Backpressure: writes to a full lane drop unless a same-cycle pop frees a slot.
module psum_col_fifo
    import corelet_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr,
    input  logic [psum_bw-1:0] i_dat,
    input  logic               i_pop,
    output logic [psum_bw-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);
    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [psum_bw-1:0] r_mem [depth];
    logic               w_wr_acc;

    assign o_empty  = (r_wptr == r_rptr);
    assign o_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign o_head   = r_mem[r_rptr[AW-1:0]];
    // The pop is resolved first, so a full lane still accepts when popped this cycle.
    assign w_wr_acc = i_wr && (!o_full || i_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + PW'(1);
            if (i_pop)    r_rptr <= r_rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wptr[AW-1:0]] <= i_dat;
    end
endmodule

// File: rtl/psum_collector.sv
// Skewed per-column psum lanes drained as whole rows; PSUM_COLLECTOR_OVF_EN adds a sticky overflow flag.
// Latency: accepted rd presents the row on out/o_valid after the same edge.
// Backpressure: rd ignored until every lane is non-empty; writes to full lanes drop.
module psum_collector
    import corelet_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready
`ifdef PSUM_COLLECTOR_OVF_EN
    ,
    output logic                   o_overflow
`endif
);
    logic [col-1:0]         w_full;
    logic [col-1:0]         w_empty;
    logic [col*psum_bw-1:0] w_head;
    logic                   w_pop;
    logic [col*psum_bw-1:0] r_out;
    logic                   r_valid;

    assign o_ready = &(~w_empty);
    assign o_full  = |w_full;
    assign w_pop   = rd && o_ready;
    assign out     = r_out;
    assign o_valid = r_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (wr[i]),
            .i_dat   (in[psum_bw*i +: psum_bw]),
            .i_pop   (w_pop),
            .o_head  (w_head[psum_bw*i +: psum_bw]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) r_out <= w_head;
        end
    end

`ifdef PSUM_COLLECTOR_OVF_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (|(wr & w_full & {col{~w_pop}})) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;
`endif
endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: directed vector table, corner sequences, and
// randomized traffic checked against per-lane queue reference model.
module tb_psum_collector;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_s;
    logic [7:0]   wr_s;
    logic         rd_s;
    logic [127:0] out_s;
    logic         valid_s, full_s, ready_s;
`ifdef PSUM_COLLECTOR_OVF_EN
    logic         ovf_s;
`endif

    always #5 clk = ~clk;

    psum_collector dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_s),
        .wr         (wr_s),
        .rd         (rd_s),
        .out        (out_s),
        .o_valid    (valid_s),
        .o_full     (full_s),
        .o_ready    (ready_s)
`ifdef PSUM_COLLECTOR_OVF_EN
        ,
        .o_overflow (ovf_s)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one queue per lane plus the last popped row.
    logic [15:0]  q [8][$];
    logic [127:0] m_out;
    logic         m_valid;
    logic         m_ovf;

    typedef struct {
        logic [7:0]   wr;
        logic [127:0] din;
        logic         rd;
        logic         exp_ready;
        logic         exp_valid;
        logic [127:0] exp_out;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic m_ready();
        logic r = 1'b1;
        for (int l = 0; l < 8; l++) if (q[l].size() == 0) r = 1'b0;
        return r;
    endfunction

    function automatic logic m_full();
        logic f = 1'b0;
        for (int l = 0; l < 8; l++) if (q[l].size() == 16) f = 1'b1;
        return f;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int l = 0; l < 8; l++) q[l].delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/out"},   out_s,   m_out);
        chk({tag, "/valid"}, valid_s, m_valid);
        chk({tag, "/ready"}, ready_s, m_ready());
        chk({tag, "/full"},  full_s,  m_full());
`ifdef PSUM_COLLECTOR_OVF_EN
        chk({tag, "/ovf"},   ovf_s,   m_ovf);
`endif
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic [7:0] w, input logic [127:0] d, input logic r, input string tag);
        logic pop;
        wr_s = w;
        in_s = d;
        rd_s = r;
        pop  = r && m_ready();
        for (int l = 0; l < 8; l++)
            if (w[l] && q[l].size() == 16 && !pop) m_ovf = 1'b1;
        if (pop)
            for (int l = 0; l < 8; l++) m_out[16*l +: 16] = q[l].pop_front();
        for (int l = 0; l < 8; l++)
            if (w[l] && q[l].size() < 16) q[l].push_back(d[16*l +: 16]);
        m_valid = pop;
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        wr_s  = 8'hFF;
        rd_s  = 1'b1;
        in_s  = rnd128();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk({tag, "/in_rst_out"},   out_s,   128'h0);
            chk({tag, "/in_rst_valid"}, valid_s, 1'b0);
            chk({tag, "/in_rst_ready"}, ready_s, 1'b0);
            chk({tag, "/in_rst_full"},  full_s,  1'b0);
`ifdef PSUM_COLLECTOR_OVF_EN
            chk({tag, "/in_rst_ovf"},   ovf_s,   1'b0);
`endif
            @(posedge clk);
            #1;
        end
        wr_s = '0;
        rd_s = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        check_state({tag, "/post_rst"});
    endtask

    initial begin
        logic [127:0] row;
        logic [127:0] rows [17];
        logic [127:0] nrow, a, b, c, d, e;
        logic [15:0]  v;

        reset = 1'b0;
        wr_s  = '0;
        rd_s  = 1'b0;
        in_s  = '0;
        model_clear();

        // Reset with wr/rd active throughout.
        do_reset("reset");

        // Skewed fill, one lane per cycle, then a single pop.
        row = '0;
        for (int i = 0; i < 8; i++) begin
            v = 16'h0100 + 16'(i);
            row[16*i +: 16]   = v;
            tbl[i].wr         = 8'(1 << i);
            tbl[i].din        = {8{v}};
            tbl[i].rd         = 1'b0;
            tbl[i].exp_ready  = (i == 7);
            tbl[i].exp_valid  = 1'b0;
            tbl[i].exp_out    = '0;
        end
        tbl[8] = '{wr: 8'h00, din: '0, rd: 1'b1, exp_ready: 1'b0, exp_valid: 1'b1, exp_out: row};
        tbl[9] = '{wr: 8'h00, din: '0, rd: 1'b1, exp_ready: 1'b0, exp_valid: 1'b0, exp_out: row};
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].wr, tbl[k].din, tbl[k].rd, "skew");
            chk("tbl_ready", ready_s, tbl[k].exp_ready);
            chk("tbl_valid", valid_s, tbl[k].exp_valid);
            chk("tbl_out",   out_s,   tbl[k].exp_out);
        end

        // Fill to full, drop a 17th row, drain in order.
        for (int j = 0; j < 17; j++) begin
            rows[j] = rnd128();
            step(8'hFF, rows[j], 1'b0, "fill");
            if (j == 15) chk("full_after_16", full_s, 1'b1);
        end
        for (int j = 0; j < 16; j++) begin
            step(8'h00, '0, 1'b1, "drain");
            chk("drain_row", out_s, rows[j]);
        end
        step(8'h00, '0, 1'b1, "no_17th");
        chk("no_17th_valid", valid_s, 1'b0);
        chk("no_17th_out",   out_s,   rows[15]);

        // Full lanes with a simultaneous pop and write.
        do_reset("reset2");
        for (int j = 0; j < 16; j++) begin
            rows[j] = rnd128();
            step(8'hFF, rows[j], 1'b0, "fill2");
        end
        nrow = rnd128();
        step(8'hFF, nrow, 1'b1, "full_pop");
        chk("full_pop_out",  out_s,  rows[0]);
        chk("full_pop_full", full_s, 1'b1);
        for (int j = 0; j < 16; j++) step(8'h00, '0, 1'b1, "drain2");
        chk("new_row_last", out_s, nrow);

        // Wrap-around: occupancy 1 with write and pop every cycle.
        step(8'hFF, rnd128(), 1'b0, "wrap_pre");
        for (int k = 0; k < 40; k++) begin
            step(8'hFF, rnd128(), 1'b1, "wrap");
            chk("wrap_valid", valid_s, 1'b1);
        end
        step(8'h00, '0, 1'b1, "wrap_last");

        // Read while lane 3 is empty must not move any pointer.
        a = rnd128(); b = rnd128(); c = rnd128(); d = rnd128();
        e = out_s;
        step(8'hF7, a, 1'b0, "inv_w");
        step(8'hF7, b, 1'b0, "inv_w");
        step(8'h00, '0, 1'b1, "inv_rd");
        chk("inv_valid", valid_s, 1'b0);
        chk("inv_out",   out_s,   e);
        step(8'h08, c, 1'b0, "inv_w3");
        step(8'h08, d, 1'b0, "inv_w3");
        step(8'h00, '0, 1'b1, "inv_pop1");
        row = a;
        row[48 +: 16] = c[48 +: 16];
        chk("inv_pop1_row", out_s, row);
        step(8'h00, '0, 1'b1, "inv_pop2");
        row = b;
        row[48 +: 16] = d[48 +: 16];
        chk("inv_pop2_row", out_s, row);

        // Randomized traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            step(8'($urandom_range(0, 255)) | ((k % 3 == 0) ? 8'hFF : 8'h00),
                 rnd128(), ($urandom_range(0, 3) < 2), "rand");
        end
        do_reset("reset_mid");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
